// File: rtl/light_tracker_pkg.sv
// Shared types and helpers for the light velocity tracker: FSM state encoding,
// divider width calculation and the symmetric saturation clamp.
package light_tracker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRACK = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    DONE  = 3'd4
  } tracker_state_t;

  // Dividend width: widest coordinate magnitude plus the fractional pre-shift.
  function automatic int calc_dw(input int x_w, input int y_w, input int frac_bits);
    return ((x_w > y_w) ? x_w : y_w) + frac_bits;
  endfunction

  // Clamp a magnitude to 2^(v_w-1)-1 so that negation never reaches the most negative code.
  function automatic logic [31:0] clamp_mag(input logic [31:0] mag, input int v_w);
    logic [31:0] lim;
    lim = (32'd1 << (v_w - 1)) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, WIDTH cycles per divide.
// A zero divisor yields an all-ones quotient.
module seq_divider #(
  parameter int WIDTH = 15,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_r;
  logic [DIV_W-1:0] rem_r;
  logic [DIV_W-1:0] div_r;
  logic [CW-1:0]    cnt_r;
  logic             run_r;
  logic             done_r;
  logic [DIV_W:0]   shifted_s;
  logic [DIV_W:0]   diff_s;

  // The dividend shifts out of quo_r's MSB while quotient bits shift in at the LSB.
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, div_r};

  // Load on start, then one restoring step per cycle until the counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r  <= {WIDTH{1'b0}};
      rem_r  <= {DIV_W{1'b0}};
      div_r  <= {DIV_W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        quo_r <= dividend;
        rem_r <= {DIV_W{1'b0}};
        div_r <= divisor;
        cnt_r <= CW'(WIDTH);
        run_r <= 1'b1;
      end else if (run_r) begin
        if (!diff_s[DIV_W]) begin
          rem_r <= diff_s[DIV_W-1:0];
          quo_r <= {quo_r[WIDTH-2:0], 1'b1};
        end else begin
          rem_r <= shifted_s[DIV_W-1:0];
          quo_r <= {quo_r[WIDTH-2:0], 1'b0};
        end
        cnt_r <= cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          run_r  <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_r;
  assign done     = done_r;

endmodule

// File: rtl/light_velocity_tracker.sv
// Tracks one contiguous light event and reports signed fixed-point X/Y velocity.
// Optional macro LIGHT_TRACKER_GAP_TOLERANCE_EN lets up to GAP_MAX dark samples sit inside an event.
module light_velocity_tracker
  import light_tracker_pkg::*;
#(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int CNT_W       = 16,
  parameter int V_W         = 16,
  parameter int FRAC_BITS   = 4,
  parameter int MIN_SAMPLES = 2,
  parameter int GAP_MAX     = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  input  logic             light_in,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  output logic [V_W-1:0]   vx_out,
  output logic [V_W-1:0]   vy_out,
  output logic [CNT_W-1:0] samples_out,
  output logic             sat_out,
  output logic             valid_out,
  output logic             busy_out
);

  localparam int DW = calc_dw(X_W, Y_W, FRAC_BITS);

  if (MIN_SAMPLES < 2 || GAP_MAX < 0) begin : g_param_check
    $error("light_velocity_tracker: MIN_SAMPLES must be >= 2 and GAP_MAX >= 0");
  end

  tracker_state_t   state_r;
  logic [X_W-1:0]   x_start_r, x_end_r, abs_x_r;
  logic [Y_W-1:0]   y_start_r, y_end_r, abs_y_r;
  logic             neg_x_r, neg_y_r;
  logic [CNT_W-1:0] count_r, divisor_r;
  logic             start_r;
  logic [DW-1:0]    qx_r;
  logic [V_W-1:0]   vx_r, vy_r;
  logic [CNT_W-1:0] samples_r;
  logic             sat_r, valid_r, busy_r;

  logic             light_s, dark_s, end_event_s, long_enough_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             div_start_s, div_done_s;
  logic [DW-1:0]    div_dividend_s, div_quotient_s;
  logic [31:0]      mag_x_s, mag_y_s;
  logic [V_W-1:0]   vx_s, vy_s;
  logic             sat_s;

  assign light_s       = valid_in & light_in;
  assign dark_s        = valid_in & ~light_in;
  assign long_enough_s = (count_r >= CNT_W'(MIN_SAMPLES));
  assign count_inc_s   = (count_r == {CNT_W{1'b1}}) ? count_r : count_r + CNT_W'(1);

`ifdef LIGHT_TRACKER_GAP_TOLERANCE_EN
  localparam int GAP_W = $clog2(GAP_MAX + 1) + 1;
  logic [GAP_W-1:0] gap_r;

  assign end_event_s = dark_s && (gap_r == GAP_W'(GAP_MAX));

  // Dark-run length inside the current event; any light sample clears it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gap_r <= {GAP_W{1'b0}};
    end else if (state_r != TRACK || light_s) begin
      gap_r <= {GAP_W{1'b0}};
    end else if (dark_s && !end_event_s) begin
      gap_r <= gap_r + GAP_W'(1);
    end else begin
      gap_r <= gap_r;
    end
  end
`else
  assign end_event_s = dark_s;
`endif

  // X starts one cycle after the operands are latched; Y is chained on X's done pulse
  // so the divider never idles between the two passes.
  assign div_start_s    = start_r | ((state_r == DIV_X) & div_done_s);
  assign div_dividend_s = start_r ? (DW'(abs_x_r) << FRAC_BITS) : (DW'(abs_y_r) << FRAC_BITS);

  seq_divider #(
    .WIDTH (DW),
    .DIV_W (CNT_W)
  ) u_div (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .start    (div_start_s),
    .dividend (div_dividend_s),
    .divisor  (divisor_r),
    .quotient (div_quotient_s),
    .done     (div_done_s)
  );

  assign mag_x_s = clamp_mag(32'(qx_r), V_W);
  assign mag_y_s = clamp_mag(32'(div_quotient_s), V_W);
  assign sat_s   = (mag_x_s != 32'(qx_r)) | (mag_y_s != 32'(div_quotient_s));
  assign vx_s    = neg_x_r ? V_W'(32'd0 - mag_x_s) : V_W'(mag_x_s);
  assign vy_s    = neg_y_r ? V_W'(32'd0 - mag_y_s) : V_W'(mag_y_s);

  // Event capture, divide sequencing and result registration.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      x_start_r <= {X_W{1'b0}};
      x_end_r   <= {X_W{1'b0}};
      abs_x_r   <= {X_W{1'b0}};
      y_start_r <= {Y_W{1'b0}};
      y_end_r   <= {Y_W{1'b0}};
      abs_y_r   <= {Y_W{1'b0}};
      neg_x_r   <= 1'b0;
      neg_y_r   <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      divisor_r <= {CNT_W{1'b0}};
      start_r   <= 1'b0;
      qx_r      <= {DW{1'b0}};
      vx_r      <= {V_W{1'b0}};
      vy_r      <= {V_W{1'b0}};
      samples_r <= {CNT_W{1'b0}};
      sat_r     <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (light_s) begin
            x_start_r <= x_in;
            x_end_r   <= x_in;
            y_start_r <= y_in;
            y_end_r   <= y_in;
            count_r   <= CNT_W'(1);
            state_r   <= TRACK;
          end
        end
        TRACK: begin
          if (light_s) begin
            x_end_r <= x_in;
            y_end_r <= y_in;
            count_r <= count_inc_s;
          end else if (end_event_s) begin
            if (!long_enough_s) begin
              state_r <= IDLE;
            end else begin
              // Magnitude and sign of the end-minus-start displacement.
              neg_x_r   <= (x_end_r < x_start_r);
              abs_x_r   <= (x_end_r < x_start_r) ? x_start_r - x_end_r : x_end_r - x_start_r;
              neg_y_r   <= (y_end_r < y_start_r);
              abs_y_r   <= (y_end_r < y_start_r) ? y_start_r - y_end_r : y_end_r - y_start_r;
              divisor_r <= count_r - CNT_W'(1);
              start_r   <= 1'b1;
              busy_r    <= 1'b1;
              state_r   <= DIV_X;
            end
          end
        end
        DIV_X: begin
          if (div_done_s) begin
            qx_r    <= div_quotient_s;
            state_r <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done_s) begin
            vx_r      <= vx_s;
            vy_r      <= vy_s;
            samples_r <= count_r;
            sat_r     <= sat_s;
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign vx_out      = vx_r;
  assign vy_out      = vy_r;
  assign samples_out = samples_r;
  assign sat_out     = sat_r;
  assign valid_out   = valid_r;
  assign busy_out    = busy_r;

endmodule

// File: tb/tb_light_velocity_tracker.sv
// Directed bench for light_velocity_tracker: a default instance and a V_W=8 instance
// share one stimulus stream; expectations follow LIGHT_TRACKER_GAP_TOLERANCE_EN.
module tb_light_velocity_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, light_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;

  logic [15:0] vx, vy, samples;
  logic        sat, valid_o, busy;
  logic [7:0]  vx8, vy8;
  logic [15:0] samples8;
  logic        sat8, valid8, busy8;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc;

`ifdef LIGHT_TRACKER_GAP_TOLERANCE_EN
  localparam int N_DARK = 4;
`else
  localparam int N_DARK = 1;
`endif

  always #5 clk = ~clk;

  light_velocity_tracker dut (
    .clk_in (clk), .rst_n_in (rst_n), .valid_in (valid_in), .light_in (light_in),
    .x_in (x_in), .y_in (y_in), .vx_out (vx), .vy_out (vy), .samples_out (samples),
    .sat_out (sat), .valid_out (valid_o), .busy_out (busy)
  );

  light_velocity_tracker #(.V_W(8)) dut8 (
    .clk_in (clk), .rst_n_in (rst_n), .valid_in (valid_in), .light_in (light_in),
    .x_in (x_in), .y_in (y_in), .vx_out (vx8), .vy_out (vy8), .samples_out (samples8),
    .sat_out (sat8), .valid_out (valid8), .busy_out (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic sample(input logic l, input logic [10:0] x, input logic [9:0] y);
    @(negedge clk);
    valid_in = 1'b1;
    light_in = l;
    x_in     = x;
    y_in     = y;
  endtask

  task automatic end_event();
    repeat (N_DARK) sample(1'b0, 11'd0, 10'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      light_in = 1'b0;
    end
  endtask

  // Returns how many edges after the last driven sample valid_out was seen, or -1.
  task automatic wait_valid(input int max_cyc, output int c);
    c = -1;
    for (int i = 0; i < max_cyc && c < 0; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      light_in = 1'b0;
      if (valid_o === 1'b1) c = i;
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; light_in = 1'b0; x_in = 11'd0; y_in = 10'd0;
    repeat (3) @(negedge clk);
    check("reset_vx", {16'd0, vx}, 32'd0);
    check("reset_samples", {16'd0, samples}, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_busy", {30'd0, busy, busy8}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Steady +5 px/sample in x: 20<<4 / 4 = 80.
    for (int k = 0; k < 5; k++) sample(1'b1, 11'(100 + 5 * k), 10'd50);
    end_event();
    wait_valid(60, cyc);
    check("t1_latency", cyc, 32'd33);
    check("t1_vx", {16'd0, vx}, 32'd80);
    check("t1_vy", {16'd0, vy}, 32'd0);
    check("t1_samples", {16'd0, samples}, 32'd5);
    check("t1_sat", {31'd0, sat}, 32'd0);
    check("t1_vx8", {24'd0, vx8}, 32'd80);
    idle(1);
    check("t1_valid_pulse", {31'd0, valid_o}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // y falls 300 -> 200 over 11 samples: -(100<<4)/10 = -160.
    for (int k = 0; k < 11; k++) sample(1'b1, 11'd400, 10'(300 - 10 * k));
    end_event();
    wait_valid(60, cyc);
    check("t2_latency", cyc, 32'd33);
    check("t2_vy", {16'd0, vy}, 32'h0000ff60);
    check("t2_vx", {16'd0, vx}, 32'd0);
    check("t2_samples", {16'd0, samples}, 32'd11);
    check("t2_vy8_clamp", {24'd0, vy8}, 32'h81);
    check("t2_sat8", {31'd0, sat8}, 32'd1);

    // Single light sample is too short to report.
    sample(1'b1, 11'd5, 10'd5);
    end_event();
    wait_valid(60, cyc);
    check("t3_short_no_valid", cyc, 32'hffffffff);
    check("t3_short_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 5; k++) sample(1'b1, 11'(200 - 5 * k), 10'd7);
    end_event();
    wait_valid(60, cyc);
    check("t3_vx", {16'd0, vx}, 32'h0000ffb0);
    check("t3_samples", {16'd0, samples}, 32'd5);

    // Two samples 200 apart: 3200 fits 16 bits, clamps to +/-127 at 8 bits.
    sample(1'b1, 11'd0, 10'd0);
    sample(1'b1, 11'd200, 10'd0);
    end_event();
    wait_valid(60, cyc);
    check("t4_valid8", {31'd0, valid8}, 32'd1);
    check("t4_vx8", {24'd0, vx8}, 32'h7f);
    check("t4_sat8", {31'd0, sat8}, 32'd1);
    check("t4_samples8", {16'd0, samples8}, 32'd2);
    check("t4_vx16", {16'd0, vx}, 32'd3200);
    check("t4_sat16", {31'd0, sat}, 32'd0);
    sample(1'b1, 11'd200, 10'd0);
    sample(1'b1, 11'd0, 10'd0);
    end_event();
    wait_valid(60, cyc);
    check("t4_neg_vx8", {24'd0, vx8}, 32'h81);
    check("t4_neg_vx16", {16'd0, vx}, 32'h0000f380);

    // Light samples while dividing are dropped.
    sample(1'b1, 11'd100, 10'd50);
    sample(1'b1, 11'd104, 10'd50);
    end_event();
    for (int k = 0; k < 3; k++) sample(1'b1, 11'd500, 10'd500);
    check("t5_busy_div", {31'd0, busy}, 32'd1);
    wait_valid(60, cyc);
    check("t5_vx", {16'd0, vx}, 32'd64);
    check("t5_samples", {16'd0, samples}, 32'd2);
    // This light lands on the valid_out cycle and must be dropped.
    valid_in = 1'b1; light_in = 1'b1; x_in = 11'd0; y_in = 10'd50;
    sample(1'b1, 11'd16, 10'd50);
    sample(1'b1, 11'd32, 10'd50);
    end_event();
    wait_valid(60, cyc);
    check("t5_drop_done_samples", {16'd0, samples}, 32'd2);
    check("t5_drop_done_vx", {16'd0, vx}, 32'd256);

    // Reset during DIV_Y clears outputs at once and aborts the event.
    sample(1'b1, 11'd100, 10'd50);
    sample(1'b1, 11'd104, 10'd50);
    end_event();
    idle(25);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vx", {16'd0, vx}, 32'd0);
    check("t6_rst_samples", {16'd0, samples}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(60, cyc);
    check("t6_no_valid", cyc, 32'hffffffff);

    // L,L,D,D ... L,L,D,D,D,D: one merged event or two separate pairs.
    sample(1'b1, 11'd10, 10'd0);
    sample(1'b1, 11'd20, 10'd0);
    sample(1'b0, 11'd0, 10'd0);
    sample(1'b0, 11'd0, 10'd0);
    wait_valid(45, cyc);
`ifdef LIGHT_TRACKER_GAP_TOLERANCE_EN
    check("t7_gap_no_early", cyc, 32'hffffffff);
`else
    check("t7_pair1_seen", {31'd0, cyc >= 0}, 32'd1);
    check("t7_pair1_vx", {16'd0, vx}, 32'd160);
    check("t7_pair1_samples", {16'd0, samples}, 32'd2);
`endif
    idle(3);
    sample(1'b1, 11'd30, 10'd0);
    sample(1'b1, 11'd50, 10'd0);
    repeat (4) sample(1'b0, 11'd0, 10'd0);
    wait_valid(60, cyc);
`ifdef LIGHT_TRACKER_GAP_TOLERANCE_EN
    check("t7_gap_vx", {16'd0, vx}, 32'd213);
    check("t7_gap_samples", {16'd0, samples}, 32'd4);
`else
    check("t7_pair2_vx", {16'd0, vx}, 32'd320);
    check("t7_pair2_samples", {16'd0, samples}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
